// File: rtl/com_fifo_buf.sv
// UART-side byte buffer: RX and TX FIFOs behind a data/status register pair.
// RX raises a level interrupt while non-empty; TX drains through a start/gap/hold FSM.
module com_fifo_buf #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxdReady_i,
  input  logic [7:0]  rxdData_i,
  input  logic        txdBusy_i,
  output logic        txdStart_o,
  output logic [7:0]  txdData_o,
  input  logic        enable_i,
  input  logic        readEnable_i,
  input  logic        mode_i,
  input  logic [31:0] dataSave_i,
  output logic [31:0] dataLoad_o,
  output logic        int_o
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_GAP, S_HOLD} state_t;

  // Reset asserts asynchronously and is released on the second clk edge after rst rises.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rst_sync <= 2'b00;
    else      r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  logic          r_ready;
  logic [7:0]    r_rx_mem [DEPTH];
  logic [AW-1:0] r_rx_wptr, r_rx_rptr;
  logic [AW:0]   r_rx_count, w_rx_count_next;
  logic          r_overrun;
  logic [7:0]    r_tx_mem [DEPTH];
  logic [AW-1:0] r_tx_wptr, r_tx_rptr;
  logic [AW:0]   r_tx_count;
  state_t        r_state, w_state_next;
  logic          r_txd_start;
  logic [7:0]    r_txd_data;
  logic          r_int;

  logic w_data_rd, w_stat_rd, w_data_wr;
  logic w_rx_full, w_rx_empty, w_rx_push, w_rx_pop, w_overrun_evt;
  logic w_tx_full, w_tx_empty, w_tx_push, w_tx_pop;
  logic w_unused;

  assign w_unused = ^dataSave_i[31:8];

  assign w_data_rd = r_ready & enable_i & readEnable_i & ~mode_i;
  assign w_stat_rd = r_ready & enable_i & readEnable_i & mode_i;
  assign w_data_wr = r_ready & enable_i & ~readEnable_i & ~mode_i;

  assign w_rx_full     = r_rx_count[AW];
  assign w_rx_empty    = (r_rx_count == '0);
  assign w_rx_pop      = w_data_rd & ~w_rx_empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign w_rx_push     = rxdReady_i & (~w_rx_full | w_rx_pop);
  assign w_overrun_evt = rxdReady_i & w_rx_full & ~w_rx_pop;

  assign w_tx_full  = r_tx_count[AW];
  assign w_tx_empty = (r_tx_count == '0);
  assign w_tx_push  = w_data_wr & ~w_tx_full;
  assign w_tx_pop   = (r_state == S_START);

  always_comb begin
    w_rx_count_next = r_rx_count;
    if (w_rx_push && !w_rx_pop)      w_rx_count_next = r_rx_count + {{AW{1'b0}}, 1'b1};
    else if (w_rx_pop && !w_rx_push) w_rx_count_next = r_rx_count - {{AW{1'b0}}, 1'b1};
  end

  always_comb begin
    dataLoad_o = '0;
    if (w_data_rd && !w_rx_empty) dataLoad_o = {24'b0, r_rx_mem[r_rx_rptr]};
    else if (w_stat_rd)           dataLoad_o = {29'b0, r_overrun, ~w_rx_empty, ~w_tx_full};
  end

  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wptr] <= rxdData_i;
    if (w_tx_push) r_tx_mem[r_tx_wptr] <= dataSave_i[7:0];
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_ready    <= 1'b0;
      r_rx_wptr  <= '0;
      r_rx_rptr  <= '0;
      r_rx_count <= '0;
      r_overrun  <= 1'b0;
      r_int      <= 1'b0;
    end else begin
      r_ready    <= 1'b1;
      r_rx_count <= w_rx_count_next;
      r_int      <= (w_rx_count_next != '0);
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + {{(AW-1){1'b0}}, 1'b1};
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + {{(AW-1){1'b0}}, 1'b1};
      if (w_overrun_evt)  r_overrun <= 1'b1;
      else if (w_stat_rd) r_overrun <= 1'b0;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (!w_tx_empty && !txdBusy_i) w_state_next = S_START;
      S_START: w_state_next = S_GAP;
      S_GAP:   w_state_next = S_HOLD;
      S_HOLD:  if (!txdBusy_i) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state     <= S_IDLE;
      r_tx_wptr   <= '0;
      r_tx_rptr   <= '0;
      r_tx_count  <= '0;
      r_txd_start <= 1'b0;
      r_txd_data  <= 8'h00;
    end else begin
      r_state     <= w_state_next;
      r_txd_start <= (w_state_next == S_START);
      if (w_state_next == S_START) r_txd_data <= r_tx_mem[r_tx_rptr];
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + {{(AW-1){1'b0}}, 1'b1};
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + {{(AW-1){1'b0}}, 1'b1};
      if (w_tx_push && !w_tx_pop)      r_tx_count <= r_tx_count + {{AW{1'b0}}, 1'b1};
      else if (w_tx_pop && !w_tx_push) r_tx_count <= r_tx_count - {{AW{1'b0}}, 1'b1};
    end
  end

  assign txdStart_o = r_txd_start;
  assign txdData_o  = r_txd_data;
  assign int_o      = r_int;
endmodule

// File: tb/tb_com_fifo_buf.sv
// Directed bench for com_fifo_buf: RX/TX scoreboards plus a transmitter model.
module tb_com_fifo_buf;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rxdReady_i = 1'b0;
  logic [7:0]  rxdData_i = 8'h00;
  logic        txdBusy_i;
  logic        txdStart_o;
  logic [7:0]  txdData_o;
  logic        enable_i = 1'b0;
  logic        readEnable_i = 1'b0;
  logic        mode_i = 1'b0;
  logic [31:0] dataSave_i = 32'h0;
  logic [31:0] dataLoad_o;
  logic        int_o;

  logic busy_model = 1'b0;
  logic busy_force = 1'b0;
  assign txdBusy_i = busy_model | busy_force;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cnt = 0;
  int fall_cyc = 0;
  bit fall_valid = 1'b0;
  logic [7:0] rx_exp[$];
  logic [7:0] tx_exp[$];

  com_fifo_buf #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .rxdReady_i(rxdReady_i), .rxdData_i(rxdData_i),
    .txdBusy_i(txdBusy_i), .txdStart_o(txdStart_o), .txdData_o(txdData_o),
    .enable_i(enable_i), .readEnable_i(readEnable_i), .mode_i(mode_i),
    .dataSave_i(dataSave_i), .dataLoad_o(dataLoad_o), .int_o(int_o)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transmitter model: busy rises one cycle after each start and stays high for 10 cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (txdStart_o === 1'b1) begin
        start_cnt++;
        if (fall_valid) check("tx_restart_gap", ((cyc - fall_cyc) >= 1) && ((cyc - fall_cyc) <= 2), 1);
        fall_valid = 1'b0;
        if (tx_exp.size() == 0) check("tx_unexpected_start", txdStart_o, 0);
        else                    check("tx_data", txdData_o, tx_exp.pop_front());
        tick();
        check("tx_start_width", txdStart_o, 0);
        busy_model = 1'b1;
        repeat (10) tick();
        busy_model = 1'b0;
        fall_cyc = cyc;
        fall_valid = (tx_exp.size() != 0) && !busy_force;
      end
    end
  end

  task automatic rx_push(input logic [7:0] b);
    rxdReady_i = 1'b1;
    rxdData_i = b;
    if (rx_exp.size() < DEPTH) rx_exp.push_back(b);
    tick();
    rxdReady_i = 1'b0;
  endtask

  task automatic bus_read(input logic m, output logic [31:0] d);
    enable_i = 1'b1; readEnable_i = 1'b1; mode_i = m;
    #3;
    d = dataLoad_o;
    tick();
    enable_i = 1'b0; readEnable_i = 1'b0; mode_i = 1'b0;
  endtask

  task automatic bus_write(input logic m, input logic [7:0] b);
    enable_i = 1'b1; readEnable_i = 1'b0; mode_i = m;
    dataSave_i = {24'hC3A5F0, b};
    if (!m && tx_exp.size() < DEPTH) tx_exp.push_back(b);
    tick();
    enable_i = 1'b0; mode_i = 1'b0; dataSave_i = 32'h0;
  endtask

  task automatic data_read(input string tag);
    logic [31:0] d;
    logic [31:0] exp;
    exp = 32'h0;
    if (rx_exp.size() != 0) exp = {24'h0, rx_exp.pop_front()};
    bus_read(1'b0, d);
    check(tag, d, exp);
  endtask

  task automatic status_read(input string tag, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(1'b1, d);
    check(tag, d, exp);
  endtask

  task automatic wait_starts(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (start_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check(tag, start_cnt, target);
  endtask

  initial begin
    int base;
    logic [31:0] d;
    logic [31:0] exp;

    // Reset state
    repeat (3) tick();
    check("rst_txd_start", txdStart_o, 0);
    check("rst_txd_data", txdData_o, 0);
    check("rst_int", int_o, 0);
    check("rst_dataload", dataLoad_o, 0);
    rst = 1'b1;
    repeat (5) tick();
    check("idle_dataload", dataLoad_o, 0);

    // RX basic
    check("rx_int_before", int_o, 0);
    rx_push(8'h41);
    check("rx_int_after_push", int_o, 1);
    rx_push(8'h42);
    status_read("rx_status", 32'h3);
    data_read("rx_read0");
    data_read("rx_read1");
    check("rx_int_after_drain", int_o, 0);
    data_read("rx_read_empty");

    // RX overrun
    for (int i = 0; i < 17; i++) rx_push(8'(i));
    status_read("ovr_status_first", 32'h7);
    status_read("ovr_status_cleared", 32'h3);
    for (int i = 0; i < 16; i++) data_read("ovr_read");
    data_read("ovr_read_empty");
    check("ovr_int_cleared", int_o, 0);

    // Simultaneous push and pop with RX full
    for (int i = 0; i < 16; i++) rx_push(8'(8'h80 + i));
    status_read("simul_status_full", 32'h3);
    rxdReady_i = 1'b1; rxdData_i = 8'h90;
    enable_i = 1'b1; readEnable_i = 1'b1; mode_i = 1'b0;
    #3;
    d = dataLoad_o;
    exp = {24'h0, rx_exp.pop_front()};
    rx_exp.push_back(8'h90);
    check("simul_pop", d, exp);
    tick();
    rxdReady_i = 1'b0; enable_i = 1'b0; readEnable_i = 1'b0;
    status_read("simul_no_overrun", 32'h3);
    for (int i = 0; i < 16; i++) data_read("simul_order");
    data_read("simul_empty");

    // Status write is ignored
    base = start_cnt;
    bus_write(1'b1, 8'hFF);
    repeat (5) tick();
    check("stat_wr_no_start", start_cnt, base);
    status_read("stat_wr_status", 32'h1);

    // TX drain with latency check on the first byte
    base = start_cnt;
    bus_write(1'b0, 8'h55);
    check("tx_latency_early", txdStart_o, 0);
    bus_write(1'b0, 8'hAA);
    check("tx_latency_start", txdStart_o, 1);
    check("tx_latency_data", txdData_o, 8'h55);
    wait_starts("tx_drain_starts", base + 2, 200);
    repeat (40) tick();
    check("tx_drain_total", start_cnt, base + 2);
    check("tx_data_hold", txdData_o, 8'hAA);

    // TX full with the transmitter held busy
    busy_force = 1'b1;
    base = start_cnt;
    for (int i = 0; i < 15; i++) bus_write(1'b0, 8'(8'h20 + i));
    status_read("txfull_status_15", 32'h1);
    bus_write(1'b0, 8'h2F);
    status_read("txfull_status_16", 32'h0);
    bus_write(1'b0, 8'h30);
    status_read("txfull_status_17", 32'h0);
    check("txfull_held", start_cnt, base);
    busy_force = 1'b0;
    wait_starts("txfull_starts", base + 16, 600);
    repeat (40) tick();
    check("txfull_total", start_cnt, base + 16);

    // Reset during HOLD with three bytes queued
    rx_push(8'h77);
    base = start_cnt;
    for (int i = 0; i < 4; i++) bus_write(1'b0, 8'(8'h61 + i));
    repeat (3) tick();
    check("pre_rst_int", int_o, 1);
    check("pre_rst_txd_data", txdData_o, 8'h61);
    #2;
    rst = 1'b0;
    tx_exp.delete();
    rx_exp.delete();
    #1;
    check("async_rst_txd_start", txdStart_o, 0);
    check("async_rst_txd_data", txdData_o, 0);
    check("async_rst_int", int_o, 0);
    enable_i = 1'b1; readEnable_i = 1'b1; mode_i = 1'b1;
    #1;
    check("async_rst_dataload", dataLoad_o, 0);
    enable_i = 1'b0; readEnable_i = 1'b0; mode_i = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    repeat (6) tick();
    status_read("post_rst_status", 32'h1);
    repeat (40) tick();
    check("post_rst_no_start", start_cnt, base + 1);
    data_read("post_rst_rx_empty");
    check("post_rst_int", int_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/com_fifo_buf.md
COM_FIFO_BUF -- requirements
Module: com_fifo_buf

Interface
REQ-001 Parameter DEPTH, default 16, SHALL set the entries per FIFO; legal values are powers of two from 4 to 256.
REQ-002 The block SHALL have exactly these ports: clk, rst, rxdReady_i, rxdData_i, txdBusy_i, txdStart_o, txdData_o, enable_i, readEnable_i, mode_i, dataSave_i, dataLoad_o, int_o.
REQ-003 clk  in  1  single system clock (25 MHz domain); all state SHALL change on its rising edge.
REQ-004 rst  in  1  reset; asynchronous, active-low (0 = reset).
REQ-005 rxdReady_i  in  1  one-cycle pulse from the UART receiver: a byte is valid.
REQ-006 rxdData_i  in  8  received byte, valid while rxdReady_i=1.
REQ-007 txdBusy_i  in  1  UART transmitter busy.
REQ-008 txdStart_o  out  1  one-cycle start pulse to the transmitter.
REQ-009 txdData_o  out  8  byte to transmit, valid while txdStart_o=1.
REQ-010 enable_i  in  1  device-bus select for this peripheral.
REQ-011 readEnable_i  in  1  1 = read access, 0 = write access.
REQ-012 mode_i  in  1  register select (bus address bit 2): 0 = data, 1 = status.
REQ-013 dataSave_i  in  32  write data; only bits [7:0] are used.
REQ-014 dataLoad_o  out  32  read data.
REQ-015 int_o  out  1  level interrupt: the RX FIFO is non-empty.

Function
REQ-016 The block SHALL contain two independent FIFOs of DEPTH bytes each, RX and TX, each with wrapping read/write pointers and a count of log2(DEPTH)+1 bits.
REQ-017 RX push: on a cycle with rxdReady_i=1 and the RX FIFO not full, rxdData_i SHALL be written; rxdReady_i=1 while full SHALL drop the byte and set a sticky overrun flag.
REQ-018 Data read (enable_i=1, readEnable_i=1, mode_i=0) SHALL drive dataLoad_o = {24'b0, RX head} combinationally in the same cycle and pop RX at that clock edge.
REQ-019 A data read while RX is empty SHALL return 0 and leave the pointers unchanged.
REQ-020 A pop and a push in the same cycle SHALL both occur, leaving the count unchanged; when RX is full, the push SHALL be accepted.
REQ-021 Status read (enable_i=1, readEnable_i=1, mode_i=1) SHALL return {29'b0, overrun, RX not empty, TX not full} and SHALL clear overrun at that edge; an overrun event in the same cycle SHALL win, leaving overrun set.
REQ-022 Data write (enable_i=1, readEnable_i=0, mode_i=0) SHALL push dataSave_i[7:0] into TX if TX is not full, otherwise silently drop it.
REQ-023 A status write SHALL be ignored.
REQ-024 dataLoad_o SHALL be 0 whenever no read is in progress.
REQ-025 The TX drain FSM SHALL have four states: IDLE, START, GAP, HOLD.
REQ-026 IDLE SHALL go to START when TX is not empty and txdBusy_i=0.
REQ-027 In START, txdStart_o SHALL be 1 and txdData_o SHALL equal the TX head; TX SHALL pop; the next state SHALL be GAP.
REQ-028 GAP SHALL last exactly one cycle (covering the transmitter's busy-assertion delay) and then go to HOLD.
REQ-029 HOLD SHALL go to IDLE when txdBusy_i=0.
REQ-030 txdStart_o SHALL be registered and high for exactly one cycle per transmitted byte; txdData_o SHALL hold its last value outside START.
REQ-031 Latency: a byte written into an empty TX with the transmitter idle at edge N SHALL produce txdStart_o=1 in the cycle after edge N+1.
REQ-032 A write to TX during START SHALL be accepted normally.
REQ-033 int_o SHALL be registered and equal (RX count != 0), visible one cycle after the push or pop.
REQ-034 Throughput: the FSM SHALL sustain back-to-back bytes with at most one IDLE cycle between a busy deassertion and the next start.

Reset
REQ-035 Asserting rst SHALL immediately, without waiting for clk, clear both FIFO pointers and counts, clear overrun, force the FSM to IDLE, and drive txdStart_o=0, txdData_o=0, int_o=0, dataLoad_o=0.
REQ-036 Reset mid-transmission SHALL discard all queued bytes, and no txdStart_o SHALL be issued until new data is written after reset release.
REQ-037 Release of rst SHALL be synchronised internally (two flops) so that leaving reset is synchronous to clk.

Verification
REQ-038 Scenario RX basic: pulse rxdReady_i with 0x41 then 0x42 -> int_o=1 one cycle later; status reads 0x3; data reads return 0x41, then 0x42, then 0x00; int_o returns to 0.
REQ-039 Scenario RX overrun: push 17 bytes 0x00..0x10 with DEPTH=16 -> status=0x7 on the first read, then 0x3; 16 data reads return 0x00..0x0F; 0x10 is lost.
REQ-040 Scenario TX drain: write 0x55, 0xAA with txdBusy_i modelled as high for 10 cycles starting 1 cycle after start -> exactly two txdStart_o pulses, carrying 0x55 then 0xAA, the second no earlier than 1 cycle after busy falls.
REQ-041 Scenario TX full: hold txdBusy_i=1 and write 17 bytes -> status bit0=0 after the 16th write; 17th byte dropped; after busy releases, exactly 16 starts occur.
REQ-042 Scenario simultaneous RX push and pop with RX full -> count stays DEPTH, no overrun, FIFO order preserved.
REQ-043 Scenario reset mid-op: assert rst during HOLD with 3 bytes queued -> outputs zero asynchronously; after release, no txdStart_o and status=0x1.
